// File: rtl/decoder_stack_pkg.sv
// decoder_stack_pkg: default sizes, k-field width derivation and the {data, k} entry type
package decoder_stack_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_STACK_DEPTH = 16;
  function automatic int kw_of(input int dw);
    return $clog2(dw + 1);
  endfunction
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [kw_of(DEF_DATA_WIDTH)-1:0] k;
  } stack_entry_t;
endpackage

// File: rtl/decoder_stack.sv
// decoder_stack: LIFO of {data, k} pairs with combinational top-of-stack outputs
// Ports: clk/rst_n (async active-low), push/pop requests with data_in/k_in,
// data_out/k_out show the top entry (0 when empty), full/empty decoded from the count.
module decoder_stack
  import decoder_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int KW = kw_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [KW-1:0]         k_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [KW-1:0]         k_out,
  output logic                  full,
  output logic                  empty
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0] k;
  } entry_t;
  entry_t mem_q [STACK_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] top_idx, wr_idx;
  logic wr_en;
  assign full = count_q == CW'(STACK_DEPTH);
  assign empty = count_q == '0;
  assign top_idx = AW'(count_q - CW'(1));
  assign data_out = empty ? '0 : mem_q[top_idx].data;
  assign k_out = empty ? '0 : mem_q[top_idx].k;
  // push+pop on a non-empty stack replaces the top; otherwise a push lands at count
  always_comb begin
    wr_en = push && (pop || !full);
    wr_idx = (pop && !empty) ? top_idx : AW'(count_q);
    count_d = (push && !full && (!pop || empty)) ? count_q + CW'(1)
            : (pop && !push && !empty) ? count_q - CW'(1)
            : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      count_q <= count_d;
      if (wr_en) mem_q[wr_idx] <= '{data: data_in, k: k_in};
    end
  end
endmodule

// File: tb/tb_decoder_stack.sv
// tb_decoder_stack: scoreboard bench for decoder_stack at default parameters
module tb_decoder_stack;
  import decoder_stack_pkg::*;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int DEPTH = DEF_STACK_DEPTH;
  localparam int KW = kw_of(DW);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [KW-1:0] k_in = '0;
  logic [DW-1:0] data_out;
  logic [KW-1:0] k_out;
  logic full, empty;
  int checks = 0;
  int errors = 0;
  typedef struct {
    stack_entry_t top;
    logic full;
    logic empty;
  } exp_t;
  stack_entry_t mdl[$];
  exp_t sb[$];
  decoder_stack dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in), .k_in(k_in),
    .data_out(data_out), .k_out(k_out), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic [KW-1:0] k);
    exp_t e;
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    k_in = k;
    if (p && q && mdl.size() > 0) mdl[mdl.size()-1] = '{data: d, k: k};
    else if (p && mdl.size() < DEPTH) mdl.push_back('{data: d, k: k});
    else if (q && mdl.size() > 0) void'(mdl.pop_back());
    e.top = mdl.size() > 0 ? mdl[mdl.size()-1] : '0;
    e.full = mdl.size() == DEPTH;
    e.empty = mdl.size() == 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      check("sb_data", 64'(data_out), 64'(e.top.data));
      check("sb_k", 64'(k_out), 64'(e.top.k));
      check("sb_full", 64'(full), 64'(e.full));
      check("sb_empty", 64'(empty), 64'(e.empty));
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_k", 64'(k_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, DW'(i + 1), KW'((i % 5) + 1));
      check("fill_data", 64'(data_out), 64'(i + 1));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_empty", 64'(empty), 64'd0);
    check("fill_top", 64'(data_out), 64'h10);
    check("fill_k", 64'(k_out), 64'd1);
    step(1'b1, 1'b0, DW'(100), KW'(10));
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_data", 64'(data_out), 64'h10);
    check("ovf_k", 64'(k_out), 64'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0, '0);
      if (i == 0) begin
        check("pop1_data", 64'(data_out), 64'h0F);
        check("pop1_k", 64'(k_out), 64'd5);
      end
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_full", 64'(full), 64'd0);
    check("drain_data", 64'(data_out), 64'd0);
    check("drain_k", 64'(k_out), 64'd0);
    step(1'b0, 1'b1, '0, '0);
    check("udf_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, DW'((i + 1) * 10), KW'(i + 1));
      check("rnd_data", 64'(data_out), 64'((i + 1) * 10));
      check("rnd_k", 64'(k_out), 64'(i + 1));
      check("rnd_nempty", 64'(empty), 64'd0);
      step(1'b0, 1'b1, '0, '0);
      check("rnd_empty", 64'(empty), 64'd1);
    end
    step(1'b1, 1'b0, DW'(7), KW'(3));
    step(1'b1, 1'b1, DW'(9), KW'(4));
    check("rep_data", 64'(data_out), 64'd9);
    check("rep_k", 64'(k_out), 64'd4);
    step(1'b0, 1'b1, '0, '0);
    check("rep_count1", 64'(empty), 64'd1);
    step(1'b1, 1'b1, DW'(5), KW'(2));
    check("pp_empty_data", 64'(data_out), 64'd5);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, DW'(200 + i), KW'(i % 33));
    step(1'b1, 1'b1, DW'(77), KW'(7));
    check("pp_full_data", 64'(data_out), 64'd77);
    check("pp_full_full", 64'(full), 64'd1);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), DW'($urandom), KW'($urandom_range(DW)));
    while (mdl.size() > 0) step(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(i + 40), KW'(i));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_data", 64'(data_out), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    mdl.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, DW'('hAB), KW'(2));
    step(1'b1, 1'b0, DW'('hCD), KW'(3));
    step(1'b0, 1'b1, '0, '0);
    check("post_rst_e0", 64'(data_out), 64'hAB);
    step(1'b0, 1'b1, '0, '0);
    check("post_rst_empty", 64'(empty), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
